// File: rtl/c7bifu_issue_ctl_pkg.sv
// rtl/c7bifu_issue_ctl_pkg.sv - shared state encodings, MUL latency default and tracker entry layout
package c7bifu_issue_ctl_pkg;

    localparam int MUL_LAT_DEF = 3;
    localparam int RIDX_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LSU_BUSY = 2'd1,
        ST_SERIAL   = 2'd2
    } state_e;

    // One MUL tracker slot: {vld, rd[4:0]}
    typedef struct packed {
        logic              vld;
        logic [RIDX_W-1:0] rd;
    } mul_ent_t;

    function automatic logic ridx_live(input logic [RIDX_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/c7bifu_issue_ctl_mul_track.sv
// rtl/c7bifu_issue_ctl_mul_track.sv - MUL in-flight tracker: MUL_LAT-deep {vld,rd} shift with registered exit
module c7bifu_mul_track
    import c7bifu_issue_ctl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_vld,
    input  logic [RIDX_W-1:0] push_rd,
    output logic              exit_vld,
    output logic [RIDX_W-1:0] exit_rd,
    output logic              any_vld
);

    // Slots 0..MUL_LAT-1 are the pipeline; slot MUL_LAT is the writeback cycle,
    // so the result is usable MUL_LAT cycles after the consumer first sees the busy bit.
    mul_ent_t stg_q [0:MUL_LAT];

    // Shift the tracker one slot per cycle; reset empties every slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[0] <= '{vld: push_vld, rd: push_rd};
            for (int i = 1; i <= MUL_LAT; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    // Any slot valid blocks serialising instructions.
    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i <= MUL_LAT; i++) begin
            any_vld = any_vld | stg_q[i].vld;
        end
    end

    assign exit_vld = stg_q[MUL_LAT].vld;
    assign exit_rd  = stg_q[MUL_LAT].rd;

endmodule

// File: rtl/c7bifu_issue_ctl.sv
// rtl/c7bifu_issue_ctl.sv - decode issue controller; C7BIFU_ISSUE_WB_BYPASS_EN enables writeback-cycle bypass
module c7bifu_issue_ctl
    import c7bifu_issue_ctl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int NREG    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_vld_d,
    input  logic [RIDX_W-1:0] dec_rs1_d,
    input  logic [RIDX_W-1:0] dec_rs2_d,
    input  logic [RIDX_W-1:0] dec_rd_d,
    input  logic              dec_wen_d,
    input  logic              dec_lsu_d,
    input  logic              dec_mul_d,
    input  logic              dec_serial_d,
    input  logic              exu_lsu_done,
    input  logic [RIDX_W-1:0] exu_lsu_rd,
    input  logic              exu_lsu_wen,
    input  logic              flush,
    output logic              ifu_stall,
    output logic              ctl_issue_d,
    output logic [1:0]        ctl_state,
    output logic [NREG-1:0]   ctl_sb_busy
);

    state_e            state_q;
    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_set;
    logic [NREG-1:0]   sb_clr;
    logic [NREG-1:0]   sb_chk;
    logic              trk_exit_vld;
    logic [RIDX_W-1:0] trk_exit_rd;
    logic              trk_any;
    logic              trk_push;
    logic              haz_raw;
    logic              haz_waw;
    logic              haz_lsu;
    logic              haz_ser;
    logic              hazard;
    logic              issue;

    c7bifu_mul_track #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_track (
        .clk      (clk),
        .reset    (reset),
        .push_vld (trk_push),
        .push_rd  (dec_rd_d),
        .exit_vld (trk_exit_vld),
        .exit_rd  (trk_exit_rd),
        .any_vld  (trk_any)
    );

    // Busy bits released this cycle by LSU completion or MUL tracker exit.
    always_comb begin
        sb_clr = '0;
        if (exu_lsu_done && exu_lsu_wen && ridx_live(exu_lsu_rd)) begin
            sb_clr[exu_lsu_rd] = 1'b1;
        end
        if (trk_exit_vld && ridx_live(trk_exit_rd)) begin
            sb_clr[trk_exit_rd] = 1'b1;
        end
    end

`ifdef C7BIFU_ISSUE_WB_BYPASS_EN
    assign sb_chk = sb_q & ~sb_clr;
`else
    assign sb_chk = sb_q;
`endif

    // Hazard detection against the decode fields; r0 never stalls.
    always_comb begin
        haz_raw = (ridx_live(dec_rs1_d) && sb_chk[dec_rs1_d]) ||
                  (ridx_live(dec_rs2_d) && sb_chk[dec_rs2_d]);
        haz_waw = dec_wen_d && ridx_live(dec_rd_d) && sb_chk[dec_rd_d];
`ifdef C7BIFU_ISSUE_WB_BYPASS_EN
        haz_lsu = dec_lsu_d && (state_q == ST_LSU_BUSY) && !exu_lsu_done;
`else
        haz_lsu = dec_lsu_d && (state_q == ST_LSU_BUSY);
`endif
        // Serialising instructions wait for every long-latency writer to drain.
        haz_ser = dec_serial_d && ((|sb_q) || trk_any);
        hazard  = haz_raw || haz_waw || haz_lsu || haz_ser;
    end

    assign issue       = dec_vld_d && !hazard && !flush;
    assign ctl_issue_d = issue;
    assign ifu_stall   = dec_vld_d && hazard && !flush;
    assign trk_push    = issue && dec_mul_d && dec_wen_d && ridx_live(dec_rd_d);

    // Busy bits raised by an issuing long-latency writer.
    always_comb begin
        sb_set = '0;
        if (issue && dec_wen_d && ridx_live(dec_rd_d) && (dec_lsu_d || dec_mul_d)) begin
            sb_set[dec_rd_d] = 1'b1;
        end
    end

    // Scoreboard update and issue FSM; set wins over clear on the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q    <= '0;
            state_q <= ST_IDLE;
        end else begin
            sb_q <= (sb_q & ~sb_clr) | sb_set;
            case (state_q)
                ST_IDLE: begin
                    if (issue && dec_lsu_d) begin
                        state_q <= ST_LSU_BUSY;
                    end else if (dec_vld_d && dec_serial_d && hazard && !flush) begin
                        state_q <= ST_SERIAL;
                    end
                end
                ST_LSU_BUSY: begin
                    if (exu_lsu_done && !(issue && dec_lsu_d)) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SERIAL: begin
                    if (issue || flush) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ctl_state   = state_q;
    assign ctl_sb_busy = sb_q;

endmodule
